divisor_seq_8bits: RTL and testbench
====================================

DIVISOR_SEQ_8BITS -- requirements
Module: divisor_seq_8bits

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-004 SHALL have port: dividendo  input  8  unsigned dividend; captured on accepted start.
REQ-005 SHALL have port: divisor  input  8  unsigned divisor; captured on accepted start.
REQ-006 SHALL have port: busy  output  1  high while in CALC.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; high exactly while in DONE.
REQ-008 SHALL have port: quociente  output  8  unsigned quotient; registered.
REQ-009 SHALL have port: resto  output  8  unsigned remainder; registered.
REQ-010 SHALL have port: div_zero  output  1  divide-by-zero flag; registered.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-012 SHALL perform an accepted start on the edge where state is IDLE and start=1: capture both operands, clear the partial remainder, load the 3-bit iteration counter with 7, clear div_zero, and enter CALC.
REQ-013 SHALL perform one restoring-division iteration per CALC cycle, MSB of the dividend first: shifted = {rem[7:0], next dividend bit}; trial = shifted - divisor.
REQ-014 SHALL compute the trial subtraction with exactly one subtrator_8bits instance; no other subtractor is permitted.
REQ-015 SHALL accept the trial, setting the quotient bit to 1 and rem to trial[7:0], when the bit shifted out of rem was 1 or the subtractor cout is 1; otherwise it SHALL set the quotient bit to 0 and rem to shifted.
REQ-016 SHALL leave CALC after 8 iterations, on the edge where counter=0, and enter DONE; quociente and resto SHALL be valid from that edge.
REQ-017 SHALL give a fixed latency: accepted start at edge k gives done=1 in the cycle after edge k+8 (9 cycles).
REQ-018 SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-019 SHALL hold quociente, resto and div_zero stable from DONE until the next accepted start.
REQ-020 SHALL ignore start in CALC and DONE: no restart and no operand capture.
REQ-021 SHALL NOT let operand input changes after acceptance affect the result in progress.
REQ-022 SHALL allow back-to-back operation: start=1 in the first IDLE cycle after DONE is accepted.

Reset
REQ-023 SHALL, on any edge where rst_n=0, set state=IDLE, busy=0, done=0, quociente=0, resto=0, div_zero=0 and counter=0.
REQ-024 SHALL give reset priority over start and over an in-progress CALC; an aborted division produces no done pulse.
REQ-025 SHALL accept a start on the first edge with rst_n=1.

Configuration
REQ-026 SHALL, when DIV_ZERO_CHECK_EN is defined, treat an accepted start with divisor=0 as follows: skip CALC, enter DONE on the next edge, set div_zero=1, quociente=8'hFF and resto=dividendo; latency is 1 cycle.
REQ-027 SHALL, when DIV_ZERO_CHECK_EN is not defined, tie div_zero to 0 and run divisor=0 through the normal 8-iteration path, giving quociente=8'hFF and resto=dividendo after 9 cycles.

Verification
REQ-028 SHALL cover: dividendo=100, divisor=7 -> done 9 cycles after start, quociente=14, resto=2, div_zero=0.
REQ-029 SHALL cover: 255/1 -> quociente=255, resto=0; 200/255 -> quociente=0, resto=200; 255/16 -> quociente=15, resto=15.
REQ-030 SHALL cover: start held high continuously with new operands during CALC -> results match the first captured operands; the next start is accepted only in the IDLE cycle after DONE.
REQ-031 SHALL cover: rst_n=0 at iteration 4 of 200/3 -> next cycle shows IDLE, busy=0, outputs 0, no done pulse; a fresh 200/3 afterwards gives quociente=66, resto=2.
REQ-032 SHALL cover: 77/0 -> with DIV_ZERO_CHECK_EN, done 1 cycle after start, div_zero=1, quociente=8'hFF, resto=77; without it, done after 9 cycles, div_zero=0, quociente=8'hFF, resto=77.

Source files
------------

// File: rtl/divisor_seq_8bits.sv
// -----------------------------------------------------------------------------
// divisor_seq_8bits
// Sequential 8-bit unsigned restoring divider. One quotient bit is resolved per
// clock in CALC, dividend MSB first, so a division takes 9 cycles from the
// accepted start to the done pulse.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : synchronous active-low reset
//   start      : begin a division (only looked at in IDLE)
//   dividendo  : 8-bit unsigned dividend, captured on accepted start
//   divisor    : 8-bit unsigned divisor, captured on accepted start
//   busy       : high while the iteration state is active
//   done       : one-cycle pulse when results are ready
//   quociente  : registered quotient, held until the next accepted start
//   resto      : registered remainder, held until the next accepted start
//   div_zero   : registered divide-by-zero flag
//
// Build option
//   DIV_ZERO_CHECK_EN : when defined, a zero divisor skips the iteration phase
//                       and reports div_zero=1, quociente=8'hFF,
//                       resto=dividendo one cycle after start. When undefined,
//                       div_zero stays 0 and a zero divisor runs the normal
//                       path, which naturally yields 8'hFF / dividendo.
//
// Also contains subtrator_8bits, the single trial subtractor of the datapath.
// -----------------------------------------------------------------------------

module subtrator_8bits (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] diff,
   output logic       cout
);
   logic [8:0] sum_s;

   // Two's-complement subtraction; cout=1 means no borrow (a >= b).
   assign sum_s = {1'b0, a} + {1'b0, ~b} + 9'd1;
   assign diff  = sum_s[7:0];
   assign cout  = sum_s[8];
endmodule

module divisor_seq_8bits (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dividendo,
   input  logic [7:0] divisor,
   output logic       busy,
   output logic       done,
   output logic [7:0] quociente,
   output logic [7:0] resto,
   output logic       div_zero
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_r;
   logic [7:0] dividend_r;  // shifts left, MSB feeds the partial remainder
   logic [7:0] divisor_r;
   logic [7:0] rem_r;
   logic [6:0] quo_r;       // only 7 bits kept; the 8th lands directly in quociente
   logic [2:0] cnt_r;

   logic [8:0] shifted_s;
   logic [7:0] trial_s;
   logic       cout_s;
   logic       accept_s;
   logic [7:0] rem_next_s;
   logic [7:0] quo_next_s;
   logic       zero_skip_s;

   assign shifted_s = {rem_r, dividend_r[7]};

   subtrator_8bits u_sub (
      .a    (shifted_s[7:0]),
      .b    (divisor_r),
      .diff (trial_s),
      .cout (cout_s)
   );

   // A set bit 8 means the shifted value is >= 256 and so always exceeds the
   // divisor, even though the 8-bit subtractor reports a borrow.
   assign accept_s = shifted_s[8] | cout_s;

`ifdef DIV_ZERO_CHECK_EN
   assign zero_skip_s = (divisor == 8'd0);
`else
   assign zero_skip_s = 1'b0;
`endif

   // Restore-or-accept selection for the next partial remainder and quotient.
   always_comb begin
      rem_next_s = shifted_s[7:0];
      quo_next_s = {quo_r, 1'b0};
      if (accept_s) begin
         rem_next_s = trial_s;
         quo_next_s = {quo_r, 1'b1};
      end else begin
         rem_next_s = shifted_s[7:0];
         quo_next_s = {quo_r, 1'b0};
      end
   end

   // Control FSM and datapath registers, including all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         dividend_r <= 8'd0;
         divisor_r  <= 8'd0;
         rem_r      <= 8'd0;
         quo_r      <= 7'd0;
         cnt_r      <= 3'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         quociente  <= 8'd0;
         resto      <= 8'd0;
         div_zero   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dividend_r <= dividendo;
                  divisor_r  <= divisor;
                  rem_r      <= 8'd0;
                  quo_r      <= 7'd0;
                  cnt_r      <= 3'd7;
                  if (zero_skip_s) begin
                     state_r   <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     div_zero  <= 1'b1;
                     quociente <= 8'hFF;
                     resto     <= dividendo;
                  end else begin
                     state_r  <= CALC;
                     busy     <= 1'b1;
                     div_zero <= 1'b0;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            CALC: begin
               dividend_r <= {dividend_r[6:0], 1'b0};
               rem_r      <= rem_next_s;
               quo_r      <= quo_next_s[6:0];
               if (cnt_r == 3'd0) begin
                  state_r   <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  quociente <= quo_next_s;
                  resto     <= rem_next_s;
               end else begin
                  cnt_r <= cnt_r - 3'd1;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_divisor_seq_8bits.sv
// -----------------------------------------------------------------------------
// tb_divisor_seq_8bits
// Directed vectors for divisor_seq_8bits. The stimulus side pushes the expected
// quotient, remainder, div_zero and the cycle at which done must appear; a
// separate monitor pops one entry per done pulse and compares.
// -----------------------------------------------------------------------------

module tb_divisor_seq_8bits;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividendo = 8'd0;
   logic [7:0] divisor = 8'd0;
   logic       busy;
   logic       done;
   logic [7:0] quociente;
   logic [7:0] resto;
   logic       div_zero;

   divisor_seq_8bits dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividendo (dividendo),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quociente (quociente),
      .resto     (resto),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   // Count rising edges; read on falling edges.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      int         due;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic done_prev = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending division", cyc);
         end else begin
            e = sb.pop_front();
            check("quociente", int'(quociente), int'(e.q));
            check("resto", int'(resto), int'(e.r));
            check("div_zero", int'(div_zero), int'(e.dz));
            check("done_cycle", cyc, e.due);
         end
         check("done_single_pulse", int'(done_prev), 0);
      end
      done_prev = done;
   end

   // Issue one division from an idle negedge; returns at a negedge with the
   // DUT back in IDLE. Operands are scrambled right after acceptance.
   task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic dz, input int lat);
      exp_t e;
      start     = 1'b1;
      dividendo = a;
      divisor   = b;
      e = '{q, r, dz, cyc + lat};
      sb.push_back(e);
      @(negedge clk);
      start     = 1'b0;
      dividendo = 8'hA5;
      divisor   = 8'h5A;
      check("busy_after_accept", int'(busy), (lat > 1) ? 1 : 0);
      repeat (lat) @(negedge clk);
      check("busy_idle", int'(busy), 0);
   endtask

   initial begin
      exp_t e;
      int   c0;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_quociente", int'(quociente), 0);
      check("rst_resto", int'(resto), 0);
      check("rst_div_zero", int'(div_zero), 0);

      // Start on the first edge with reset released.
      rst_n = 1'b1;
      do_div(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9);
      do_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9);
      do_div(8'd200, 8'd255, 8'd0,   8'd200, 1'b0, 9);
      do_div(8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 9);
      do_div(8'd7,   8'd7,   8'd1,   8'd0,   1'b0, 9);
      do_div(8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9);

      // start held high with operands changing during CALC.
      c0 = cyc;
      start     = 1'b1;
      dividendo = 8'd100;
      divisor   = 8'd7;
      e = '{8'd14, 8'd2, 1'b0, c0 + 9};
      sb.push_back(e);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         dividendo = 8'(i * 13);
         divisor   = 8'(i + 1);
      end
      // DONE ignores start; the following IDLE cycle accepts these operands.
      @(negedge clk);
      dividendo = 8'd255;
      divisor   = 8'd16;
      e = '{8'd15, 8'd15, 1'b0, cyc + 9};
      sb.push_back(e);
      @(negedge clk);
      start     = 1'b0;
      dividendo = 8'd3;
      divisor   = 8'd200;
      repeat (9) @(negedge clk);

      // Reset during iteration 4 of 200/3 aborts with no done pulse.
      start     = 1'b1;
      dividendo = 8'd200;
      divisor   = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_quociente", int'(quociente), 0);
      check("abort_resto", int'(resto), 0);
      check("abort_div_zero", int'(div_zero), 0);
      rst_n = 1'b1;
      do_div(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 9);

      // Divide by zero.
`ifdef DIV_ZERO_CHECK_EN
      do_div(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1);
`else
      do_div(8'd77, 8'd0, 8'hFF, 8'd77, 1'b0, 9);
`endif
      // A normal division afterwards clears div_zero.
      do_div(8'd128, 8'd10, 8'd12, 8'd8, 1'b0, 9);

      // Drain: anything left means a done pulse never arrived.
      repeat (20) @(negedge clk);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_done: got no done pulse expected one at cycle %0d", e.due);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
